// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad row receiver.
package keypad_pkg;

    localparam int         NUM_ROWS    = 4;
    localparam int         NUM_COLS    = 4;
    localparam int         COL_W       = $clog2(NUM_COLS);
    localparam logic [3:0] NO_KEY_ROWS = 4'b1111;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_e;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_cls_e;

    function automatic logic [2:0] count_low(input logic [0:NUM_ROWS-1] rows);
        logic [2:0] n;
        n = 3'd0;
        for (int r = 0; r < NUM_ROWS; r++)
            n = n + {2'b00, ~rows[r]};
        return n;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Generic 2-flop synchronizer with a configurable reset value.
module keypad_sync #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Keypad row receiver: aligns row samples to the scan index, classifies
// whole scan frames and debounces them into a key code with valid/ack.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:3]   i_row,
    input  logic [1:0]   i_col_count,
    input  logic         i_key_ack,
    output logic [3:0]   o_key_code,
    output logic         o_key_valid,
    output logic         o_key_held,
    output logic         o_key_overrun
);

    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [0:3]       w_row_s;
    logic [COL_W-1:0] w_col_s;

    // Column index rides through the same depth so each sample keeps its column.
    keypad_sync #(.W(NUM_ROWS), .RST_VAL(NO_KEY_ROWS)) u_row_sync (
        .clk(clk), .rst_n(rst_n), .i_d(i_row), .o_q(w_row_s)
    );
    keypad_sync #(.W(COL_W), .RST_VAL({COL_W{1'b1}})) u_col_sync (
        .clk(clk), .rst_n(rst_n), .i_d(i_col_count), .o_q(w_col_s)
    );

    logic       r_frame_sync;
    logic [4:0] r_low_cnt;
    logic       r_have_first;
    logic [3:0] r_first_code;

    logic       w_active, w_fend, w_base_have;
    logic [2:0] w_samp_low;
    logic [1:0] w_samp_row;
    logic [4:0] w_tot;
    logic [3:0] w_code;
    frame_cls_e w_cls;

    // Index 0 always restarts the frame, so a skipped index spoils one frame only.
    always_comb begin
        w_active   = r_frame_sync | (w_col_s == 2'd0);
        w_fend     = w_active & (w_col_s == 2'd3);
        w_samp_low = count_low(w_row_s);
        w_samp_row = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--)
            if (!w_row_s[r]) w_samp_row = 2'(r);
        w_base_have = (w_col_s != 2'd0) & r_have_first;
        w_tot       = ((w_col_s == 2'd0) ? 5'd0 : r_low_cnt) + {2'b00, w_samp_low};
        w_code      = w_base_have ? r_first_code : {w_samp_row, w_col_s};
        if (w_tot == 5'd0)      w_cls = NONE;
        else if (w_tot == 5'd1) w_cls = SINGLE;
        else                    w_cls = MULTI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_sync <= 1'b0;
            r_low_cnt    <= 5'd0;
            r_have_first <= 1'b0;
            r_first_code <= 4'd0;
        end else begin
            if (w_col_s == 2'd0) r_frame_sync <= 1'b1;
            if (w_fend) begin
                r_low_cnt    <= 5'd0;
                r_have_first <= 1'b0;
            end else if (w_active) begin
                r_low_cnt    <= w_tot;
                r_have_first <= w_base_have | (w_samp_low != 3'd0);
                r_first_code <= w_code;
            end
        end
    end

    kp_state_e  r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic [3:0] r_cand, w_cand_nx;
    logic       w_accept, w_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        if (w_fend) begin
            case (r_state)
                IDLE: if (w_cls == SINGLE) begin
                    w_cand_nx = w_code;
                    if (DB == 4'd1) begin
                        w_accept   = 1'b1;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = HELD;
                    end else begin
                        w_cnt_nx   = 4'd1;
                        w_state_nx = PRESS_DB;
                    end
                end
                PRESS_DB: if (w_cls == SINGLE && w_code == r_cand) begin
                    if (r_cnt + 4'd1 >= DB) begin
                        w_accept   = 1'b1;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = HELD;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end else if (w_cls == SINGLE) begin
                    w_cand_nx = w_code;
                    w_cnt_nx  = 4'd1;
                end else begin
                    w_cnt_nx   = 4'd0;
                    w_state_nx = IDLE;
                end
                HELD: if (w_cls == NONE) begin
                    if (DB == 4'd1) begin
                        w_release  = 1'b1;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = IDLE;
                    end else begin
                        w_cnt_nx   = 4'd1;
                        w_state_nx = REL_DB;
                    end
                end
                REL_DB: if (w_cls == NONE) begin
                    if (r_cnt + 4'd1 >= DB) begin
                        w_release  = 1'b1;
                        w_cnt_nx   = 4'd0;
                        w_state_nx = IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nx   = 4'd0;
                    w_state_nx = HELD;
                end
                default: begin
                    w_cnt_nx   = 4'd0;
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    // An ack on the accept edge frees the slot, so the new key loads without overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_key_code    <= 4'd0;
            o_key_valid   <= 1'b0;
            o_key_held    <= 1'b0;
            o_key_overrun <= 1'b0;
        end else begin
            o_key_overrun <= 1'b0;
            if (w_accept) begin
                o_key_held <= 1'b1;
                if (!o_key_valid || i_key_ack) begin
                    o_key_code  <= w_cand_nx;
                    o_key_valid <= 1'b1;
                end else begin
                    o_key_overrun <= 1'b1;
                end
            end else if (o_key_valid && i_key_ack) begin
                o_key_valid <= 1'b0;
            end
            if (w_release) o_key_held <= 1'b0;
        end
    end

endmodule
